// File: rtl/dcache_ctrl_fsm.sv
// Data-cache control FSM: miss evict/fill bursts, snoop write-backs and flush/halt walk.
// Optional coherence snoop support is compiled in when DCACHE_SNOOP_EN is defined.
module dcache_ctrl_fsm #(
    parameter int unsigned WORDS = 2,
    parameter int unsigned SETS  = 8,
    parameter int unsigned WAYS  = 2,
    localparam int unsigned WB   = $clog2(WORDS),
    localparam int unsigned FB   = $clog2(SETS * WAYS) + 1
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          dirty_i,
    input  logic          dhit_i,
    input  logic          dwait_i,
    input  logic          dmemren_i,
    input  logic          dmemwen_i,
    input  logic          flush_i,
    input  logic          ccwait_i,
    input  logic          ccwrite_i,
    input  logic          ccinv_i,
    output logic          dren_o,
    output logic          dwen_o,
    output logic [WB-1:0] word_sel_o,
    output logic [FB-1:0] frame_idx_o,
    output logic          invalidate_o,
    output logic          flushing_o,
    output logic          halt_o
);

`ifdef DCACHE_SNOOP_EN
    typedef enum logic [2:0] {
        StIdle, StEvict, StFill, StSnoop, StFlChk, StFlWb, StFlNext, StHalt
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle, StEvict, StFill, StFlChk, StFlWb, StFlNext, StHalt
    } state_e;
`endif

    localparam logic [WB-1:0] LastWord  = WB'(WORDS - 1);
    localparam logic [FB-1:0] NumFrames = FB'(SETS * WAYS);

    state_e        state_q, state_d;
    logic [WB-1:0] wcnt_q, wcnt_d;
    logic [FB-1:0] frame_q, frame_d;
    logic          miss, last_word, burst;
    state_e        done_state;

`ifdef DCACHE_SNOOP_EN
    logic ret_q, ret_d;
    logic snp;
    assign snp = ccwait_i & ccwrite_i;
`else
    logic unused_cc;
    assign unused_cc = ccwrite_i ^ ccinv_i;
`endif

    assign miss      = (dmemren_i | dmemwen_i) & ~dhit_i;
    assign last_word = (wcnt_q == LastWord);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= StIdle;
            wcnt_q  <= '0;
            frame_q <= '0;
`ifdef DCACHE_SNOOP_EN
            ret_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            frame_q <= frame_d;
`ifdef DCACHE_SNOOP_EN
            ret_q   <= ret_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        frame_d      = frame_q;
        burst        = 1'b0;
        done_state   = state_q;
        dren_o       = 1'b0;
        dwen_o       = 1'b0;
        invalidate_o = 1'b0;
        flushing_o   = 1'b0;
        halt_o       = 1'b0;
`ifdef DCACHE_SNOOP_EN
        ret_d        = ret_q;
`endif

        unique case (state_q)
            StIdle: begin
`ifdef DCACHE_SNOOP_EN
                if (snp) state_d = StSnoop;
                else
`endif
                if (miss && !ccwait_i) state_d = dirty_i ? StEvict : StFill;
                else if (flush_i)      state_d = StFlChk;
            end
            StEvict: begin
                dwen_o       = 1'b1;
                invalidate_o = last_word;
                burst        = 1'b1;
                done_state   = StFill;
            end
            StFill: begin
                dren_o     = 1'b1;
                burst      = 1'b1;
                done_state = StIdle;
            end
`ifdef DCACHE_SNOOP_EN
            StSnoop: begin
                dwen_o       = 1'b1;
                flushing_o   = ret_q;
                invalidate_o = last_word & ccinv_i;
                burst        = 1'b1;
                done_state   = ret_q ? StFlChk : StIdle;
                if (!dwait_i && last_word) ret_d = 1'b0;
            end
`endif
            StFlChk: begin
                flushing_o = 1'b1;
`ifdef DCACHE_SNOOP_EN
                if (snp) begin
                    state_d = StSnoop;
                    ret_d   = 1'b1;
                end else
`endif
                if (frame_q == NumFrames) state_d = StHalt;
                else                      state_d = dirty_i ? StFlWb : StFlNext;
            end
            StFlWb: begin
                dwen_o       = 1'b1;
                flushing_o   = 1'b1;
                invalidate_o = last_word;
                burst        = 1'b1;
                done_state   = StFlNext;
            end
            StFlNext: begin
                flushing_o = 1'b1;
                frame_d    = frame_q + 1'b1;
                state_d    = StFlChk;
            end
            StHalt: halt_o = 1'b1;
            default: state_d = StIdle;
        endcase

        // Shared word sequencing for every burst state; counter rewinds on exit.
        if (burst && !dwait_i) begin
            if (last_word) begin
                wcnt_d  = '0;
                state_d = done_state;
            end else begin
                wcnt_d = wcnt_q + 1'b1;
            end
        end
    end

    assign word_sel_o  = wcnt_q;
    assign frame_idx_o = (state_q == StHalt) ? '0 : frame_q;

endmodule

// File: tb/tb_dcache_ctrl_fsm.sv
// Scoreboard bench for dcache_ctrl_fsm (WORDS=4, SETS=2, WAYS=2): per-cycle expected outputs
// are queued as stimulus is driven and compared on the falling edge.
module tb_dcache_ctrl_fsm;

    localparam int unsigned Words = 4;
    localparam int unsigned Sets  = 2;
    localparam int unsigned Ways  = 2;

    logic       CLK = 1'b0;
    logic       nRST;
    logic       dirty, dhit, dwait, dmemren, dmemwen, flush, ccwait, ccwrite, ccinv;
    logic       dren, dwen, invalidate, flushing, halt;
    logic [1:0] word_sel;
    logic [2:0] frame_idx;

    typedef struct packed {
        logic       dren;
        logic       dwen;
        logic [1:0] ws;
        logic [2:0] fidx;
        logic       inv;
        logic       fl;
        logic       halt;
    } obs_t;

    obs_t  obs;
    obs_t  sb_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc_n = 0;
    string phase = "init";

    always #5 CLK = ~CLK;

    dcache_ctrl_fsm #(
        .WORDS(Words),
        .SETS (Sets),
        .WAYS (Ways)
    ) u_dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .dirty_i     (dirty),
        .dhit_i      (dhit),
        .dwait_i     (dwait),
        .dmemren_i   (dmemren),
        .dmemwen_i   (dmemwen),
        .flush_i     (flush),
        .ccwait_i    (ccwait),
        .ccwrite_i   (ccwrite),
        .ccinv_i     (ccinv),
        .dren_o      (dren),
        .dwen_o      (dwen),
        .word_sel_o  (word_sel),
        .frame_idx_o (frame_idx),
        .invalidate_o(invalidate),
        .flushing_o  (flushing),
        .halt_o      (halt)
    );

    assign obs = {dren, dwen, word_sel, frame_idx, invalidate, flushing, halt};

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    function automatic obs_t mk(input logic r, input logic w, input int ws, input int fi,
                                input logic iv, input logic fl, input logic h);
        obs_t o;
        o.dren = r;
        o.dwen = w;
        o.ws   = 2'(ws);
        o.fidx = 3'(fi);
        o.inv  = iv;
        o.fl   = fl;
        o.halt = h;
        return o;
    endfunction

    // Push the outputs expected in the current cycle, then move to just after the next edge.
    task automatic cyc(input obs_t e);
        sb_q.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        obs_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check_eq($sformatf("%s#%0d", phase, cyc_n), 16'(obs), 16'(e));
            cyc_n++;
        end
    end

    obs_t zz, hh;

    initial begin
        zz = mk(0, 0, 0, 0, 0, 0, 0);
        hh = mk(0, 0, 0, 0, 0, 0, 1);
        nRST = 1'b0;
        {dirty, dhit, dwait, dmemren, dmemwen, flush, ccwait, ccwrite, ccinv} = '0;
        @(posedge CLK);
        #1;

        phase = "reset";
        cyc(zz);
        nRST = 1'b1;
        cyc(zz);

        phase = "clean_miss";
        dmemren = 1'b1;
        cyc(zz);
        for (int w = 0; w < 4; w++) cyc(mk(1, 0, w, 0, 0, 0, 0));
        dmemren = 1'b0;
        cyc(zz);

        phase = "dirty_miss";
        dmemwen = 1'b1;
        dirty   = 1'b1;
        cyc(zz);
        cyc(mk(0, 1, 0, 0, 0, 0, 0));
        dwait = 1'b1;
        for (int i = 0; i < 3; i++) cyc(mk(0, 1, 1, 0, 0, 0, 0));
        dwait = 1'b0;
        cyc(mk(0, 1, 1, 0, 0, 0, 0));
        cyc(mk(0, 1, 2, 0, 0, 0, 0));
        cyc(mk(0, 1, 3, 0, 1, 0, 0));
        dirty = 1'b0;
        for (int w = 0; w < 4; w++) cyc(mk(1, 0, w, 0, 0, 0, 0));
        dmemwen = 1'b0;
        cyc(zz);

        phase = "ccwait_gate";
        dmemren = 1'b1;
        ccwait  = 1'b1;
        cyc(zz);
        cyc(zz);
        ccwait = 1'b0;
        cyc(zz);
        for (int w = 0; w < 4; w++) cyc(mk(1, 0, w, 0, 0, 0, 0));
        dmemren = 1'b0;
        cyc(zz);

`ifdef DCACHE_SNOOP_EN
        phase   = "idle_snoop";
        dmemren = 1'b1;
        ccwait  = 1'b1;
        ccwrite = 1'b1;
        ccinv   = 1'b1;
        cyc(zz);
        for (int w = 0; w < 3; w++) cyc(mk(0, 1, w, 0, 0, 0, 0));
        ccwait  = 1'b0;
        ccwrite = 1'b0;
        cyc(mk(0, 1, 3, 0, 1, 0, 0));
        ccinv = 1'b0;
        cyc(zz);
        for (int w = 0; w < 4; w++) cyc(mk(1, 0, w, 0, 0, 0, 0));
        dmemren = 1'b0;
        cyc(zz);
`endif

        // Frames 1 and 3 dirty; flush released right after FL_CHK entry.
        phase = "flush";
        flush = 1'b1;
        cyc(zz);
        flush = 1'b0;
        for (int f = 0; f < 4; f++) begin
            dirty = (f == 1 || f == 3);
`ifdef DCACHE_SNOOP_EN
            if (f == 2) begin
                ccwait  = 1'b1;
                ccwrite = 1'b1;
                cyc(mk(0, 0, 0, f, 0, 1, 0));
                ccwait  = 1'b0;
                ccwrite = 1'b0;
                for (int w = 0; w < 4; w++) cyc(mk(0, 1, w, 2, 0, 1, 0));
            end
`endif
            cyc(mk(0, 0, 0, f, 0, 1, 0));
            dirty = 1'b0;
            if (f == 1 || f == 3)
                for (int w = 0; w < 4; w++) cyc(mk(0, 1, w, f, w == 3, 1, 0));
            cyc(mk(0, 0, 0, f, 0, 1, 0));
        end
        cyc(mk(0, 0, 0, 4, 0, 1, 0));

        phase   = "halt";
        dmemren = 1'b1;
        ccwait  = 1'b1;
        ccwrite = 1'b1;
        ccinv   = 1'b1;
        for (int i = 0; i < 3; i++) cyc(hh);

        phase   = "reset_mid_fill";
        nRST    = 1'b0;
        ccwait  = 1'b0;
        ccwrite = 1'b0;
        ccinv   = 1'b0;
        cyc(zz);
        nRST = 1'b1;
        cyc(zz);
        cyc(mk(1, 0, 0, 0, 0, 0, 0));
        dwait = 1'b1;
        cyc(mk(1, 0, 1, 0, 0, 0, 0));
        nRST    = 1'b0;
        dmemren = 1'b0;
        dwait   = 1'b0;
        cyc(zz);
        nRST = 1'b1;
        cyc(zz);
        dmemren = 1'b1;
        cyc(zz);
        for (int w = 0; w < 4; w++) cyc(mk(1, 0, w, 0, 0, 0, 0));
        dmemren = 1'b0;
        cyc(zz);

        @(negedge CLK);
        #1;
        check_eq("sb_drain", 16'(sb_q.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl_fsm.md
# dcache_ctrl_fsm

Parametrised data-cache control FSM, the next generation of the single-block D-cache control unit. It sequences multi-word evictions and fills, coherence snoop write-backs and the end-of-program flush/halt walk over every frame in a SETS×WAYS cache. It sits between the D-cache tag/data arrays (which supply `dirty`/`dhit`) and the memory/coherence controller (`dREN`/`dWEN`/`dwait`/`cc*`).

## Interface
Parameters:
- WORDS, 2, words per block; power of two, ≥2
- SETS, 8, sets per way; power of two
- WAYS, 2, ways per set; flush walks SETS*WAYS frames

Ports (WB = $clog2(WORDS), FB = $clog2(SETS*WAYS)+1):
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- dirty  in  1  selected frame dirty (miss victim, snoop target, or frame `frame_idx` while flushing)
- dhit  in  1  tag hit for current datapath access
- dwait  in  1  memory busy; word accepted in a cycle where low
- dmemREN, dmemWEN  in  1 each  datapath access request
- flush  in  1  datapath halt request, level
- ccwait  in  1  coherence controller has a snoop pending
- ccwrite  in  1  snoop hit a dirty line; write-back needed
- ccinv  in  1  snoop requires invalidation after write-back
- dREN, dWEN  out  1 each  memory read/write request
- word_sel  out  WB  word index of current transfer
- frame_idx  out  FB  flush frame counter
- invalidate  out  1  clear valid/dirty of selected frame this cycle
- flushing  out  1  flush walk in progress
- halt  out  1  flush complete, sticky until reset

## Operation
- States: IDLE, EVICT, FILL, SNOOP, FL_CHK, FL_WB, FL_NEXT, HALT.
- miss = (dmemREN | dmemWEN) & ~dhit; snp = ccwait & ccwrite.
- IDLE priority: snp → SNOOP; else miss & ~ccwait → (dirty ? EVICT : FILL); else flush → FL_CHK; else stay.
- EVICT: dWEN=1. FILL: dREN=1. SNOOP, FL_WB: dWEN=1. In each of these, word counter wcnt advances on ~dwait; `word_sel`=wcnt.
- Last word (wcnt==WORDS-1) accepted: EVICT→FILL, FILL→IDLE, FL_WB→FL_NEXT, SNOOP→(ret ? FL_CHK : IDLE). wcnt clears to 0 on exit.
- invalidate=1 during last-word cycle of EVICT and FL_WB; during last-word cycle of SNOOP only when ccinv=1. Otherwise 0.
- FL_CHK: snp → SNOOP with ret←1; else frame_idx==SETS*WAYS → HALT; else dirty ? FL_WB : FL_NEXT. ret clears on SNOOP exit.
- FL_NEXT: frame_idx+1, → FL_CHK. frame_idx never exceeds SETS*WAYS.
- flushing=1 in FL_CHK, FL_WB, FL_NEXT, and in SNOOP when ret=1.
- HALT: halt=1, all other outputs 0, no exit except reset. Snoops are ignored in HALT: the cache is clean.
- flush deasserting after FL_CHK has been entered has no effect.
- dmemREN/dmemWEN are ignored outside IDLE. The datapath holds its request until dhit.

## Timing
- Reset: state IDLE, wcnt=0, frame_idx=0, ret=0. All outputs 0 during and after reset.
- Reset mid-transfer aborts immediately. No partial word is completed.
- Outputs are Moore (state/counter decoded) except `invalidate`, which also depends on ccinv.
- Clean miss, dwait always low: detected in cycle 0, FILL in cycles 1..WORDS, IDLE at WORDS+1.
- Dirty miss adds WORDS cycles of EVICT before FILL.
- A word stalls indefinitely while dwait=1. word_sel and dREN/dWEN stay stable.
- Flush of N frames with D dirty, no stalls: 2N + D*WORDS + 1 cycles from FL_CHK entry to HALT.

## Configuration
- DCACHE_SNOOP_EN defined: coherence behaviour as above.
- DCACHE_SNOOP_EN undefined: SNOOP state and ret are removed. ccwrite/ccinv are ignored. ccwait only gates the miss start. Flush never diverts.

## Test plan
- WORDS=2, clean miss, dwait=0 → dREN high 2 cycles, word_sel 0,1, IDLE on cycle 3, invalidate never high.
- WORDS=4, dirty miss, dwait=1 for 3 cycles on word 1 → dWEN 7 cycles (word_sel 0,1,1,1,1,2,3), invalidate on word 3, then dREN 4 cycles.
- IDLE with miss, ccwait=1, ccwrite=1, ccinv=1 → SNOOP taken before miss, dWEN 2 words, invalidate on last word, then miss serviced.
- SETS=2, WAYS=2, frames 1 and 3 dirty, flush → frame_idx 0→4, dWEN bursts only at idx 1,3, halt=1 after 2·4+2·2+1=13 cycles.
- Snoop raised in FL_CHK at frame_idx=2 → SNOOP with flushing=1, return to FL_CHK, frame_idx still 2.
- nRST low during FILL word 1 → all outputs 0 immediately. After release, state IDLE, word_sel=0.
